intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 19 +
 rtl/intr_ctrl_prio_sel.sv | 36 +++
 rtl/intr_ctrl.sv | 134 +++++++++++++
 tb/tb_intr_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// configuration register addresses and priority mode encodings.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_MODE = 2'd1;
    localparam logic [1:0] CFG_CLR  = 2'd2;
    localparam logic [1:0] CFG_GEN  = 2'd3;

    localparam int unsigned PRIO_FIXED  = 0;
    localparam int unsigned PRIO_ROTATE = 1;

endpackage

// File: rtl/intr_ctrl_prio_sel.sv
// Combinational priority encoder: lowest index wins (fixed) or lowest
// index at or after the start pointer, wrapping (rotating).
module prio_sel
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ     = 8,
    parameter int unsigned PRIO_MODE = PRIO_FIXED,
    parameter int unsigned ID_W      = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             valid,
    output logic [ID_W-1:0]  index
);

    int unsigned base;
    int unsigned pos;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        valid = |req;
        index = '0;
        base  = (PRIO_MODE == PRIO_ROTATE) ? 32'(start) : 32'd0;
        pos   = 32'd0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            pos = base + (N_IRQ - 1 - i);
            if (pos >= N_IRQ) begin
                pos = pos - N_IRQ;
            end
            if (req[pos[ID_W-1:0]]) begin
                index = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge/level maskable channels plus an edge NMI,
// presented to the core through a req/ack/eoi handshake without preemption.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ     = 8,
    parameter int unsigned PRIO_MODE = PRIO_FIXED,
    parameter int unsigned ID_W      = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             NMI,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [N_IRQ-1:0] cfg_wdata,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic             irq_nmi,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending
);

    state_t           state, state_nx;
    logic [N_IRQ-1:0] irq_q;
    logic             nmi_q;
    logic [N_IRQ-1:0] mask_en;
    logic [N_IRQ-1:0] mode;
    logic             gen;
    logic             nmi_pend;
    logic [ID_W-1:0]  ptr;

    logic             take;
    logic             ackd;
    logic             sel_valid;
    logic [ID_W-1:0]  sel_idx;
    logic [N_IRQ-1:0] edge_set;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] pend_nx;

    prio_sel #(
        .N_IRQ     (N_IRQ),
        .PRIO_MODE (PRIO_MODE),
        .ID_W      (ID_W)
    ) u_prio_sel (
        .req   (pending & mask_en & {N_IRQ{gen}}),
        .start (ptr),
        .valid (sel_valid),
        .index (sel_idx)
    );

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        ackd     = 1'b0;
        case (state)
            IDLE: begin
                if (nmi_pend || sel_valid) begin
                    state_nx = REQ;
                    take     = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nx = SVC;
                    ackd     = 1'b1;
                end
            end
            SVC: begin
                if (irq_eoi) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Edge channels latch until cleared (a same-edge set wins); level channels track IRQ.
    always_comb begin
        edge_set = IRQ & ~irq_q;
        clr      = '0;
        if (ackd && !irq_nmi) begin
            clr = N_IRQ'(1) << irq_id;
        end
        if (cfg_we && cfg_addr == CFG_CLR) begin
            clr = clr | cfg_wdata;
        end
        pend_nx = (mode & (edge_set | (pending & ~clr))) | (~mode & IRQ);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            irq_q      <= '0;
            nmi_q      <= 1'b0;
            pending    <= '0;
            nmi_pend   <= 1'b0;
            mask_en    <= '0;
            mode       <= '0;
            gen        <= 1'b0;
            ptr        <= '0;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            irq_nmi    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nx;
            irq_q      <= IRQ;
            nmi_q      <= NMI;
            pending    <= pend_nx;
            nmi_pend   <= (NMI & ~nmi_q) | (nmi_pend & ~(ackd & irq_nmi));
            irq_req    <= (state_nx == REQ);
            in_service <= (state_nx == SVC);
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_MASK: mask_en <= cfg_wdata;
                    CFG_MODE: mode    <= cfg_wdata;
                    CFG_GEN:  gen     <= cfg_wdata[0];
                    default:  ;
                endcase
            end
            if (take) begin
                irq_nmi <= nmi_pend;
                irq_id  <= nmi_pend ? '0 : sel_idx;
            end
            if (ackd && !irq_nmi) begin
                ptr <= (irq_id == ID_W'(N_IRQ - 1)) ? '0 : irq_id + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench: expected grants are queued by the stimulus, and a monitor
// checks each rising irq_req against the queue; status checks are inline.
module tb_intr_ctrl;
    import intr_ctrl_pkg::*;

    localparam int unsigned N    = 8;
    localparam int unsigned IDW  = 3;

    logic           clk = 1'b0;
    logic           rst0, rst1;
    logic           nmi;
    logic [N-1:0]   irq;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [N-1:0]   cfg_wdata;
    logic           ack, eoi;

    logic           req0, nmi0, ins0, req1, nmi1, ins1;
    logic [IDW-1:0] id0, id1;
    logic [N-1:0]   pend0, pend1;

    int checks = 0;
    int errors = 0;
    logic [IDW:0] q0[$];
    logic [IDW:0] q1[$];
    logic prev0 = 1'b0, prev1 = 1'b0;

    always #5 clk = ~clk;

    intr_ctrl #(.N_IRQ(N), .PRIO_MODE(PRIO_FIXED)) dut0 (
        .clk(clk), .rst(rst0), .NMI(nmi), .IRQ(irq),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .irq_ack(ack), .irq_eoi(eoi),
        .irq_req(req0), .irq_id(id0), .irq_nmi(nmi0),
        .in_service(ins0), .pending(pend0)
    );

    intr_ctrl #(.N_IRQ(N), .PRIO_MODE(PRIO_ROTATE)) dut1 (
        .clk(clk), .rst(rst1), .NMI(nmi), .IRQ(irq),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .irq_ack(ack), .irq_eoi(eoi),
        .irq_req(req1), .irq_id(id1), .irq_nmi(nmi1),
        .in_service(ins1), .pending(pend1)
    );

    // Monitor: every new request must match the head of that instance's queue.
    always @(negedge clk) begin
        if (req0 && !prev0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL grant0_unexpected got nmi=%0d id=%0d, none expected", nmi0, id0);
            end else if ({nmi0, id0} !== q0[0]) begin
                errors++;
                $display("FAIL grant0 got nmi=%0d id=%0d, expected nmi=%0d id=%0d",
                         nmi0, id0, q0[0][IDW], q0[0][IDW-1:0]);
                void'(q0.pop_front());
            end else begin
                void'(q0.pop_front());
            end
        end
        if (req1 && !prev1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL grant1_unexpected got nmi=%0d id=%0d, none expected", nmi1, id1);
            end else if ({nmi1, id1} !== q1[0]) begin
                errors++;
                $display("FAIL grant1 got nmi=%0d id=%0d, expected nmi=%0d id=%0d",
                         nmi1, id1, q1[0][IDW], q1[0][IDW-1:0]);
                void'(q1.pop_front());
            end else begin
                void'(q1.pop_front());
            end
        end
        prev0 = req0;
        prev1 = req1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [N-1:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    endtask

    task automatic setup(input logic [N-1:0] mask, input logic [N-1:0] md, input logic g);
        cfg_write(CFG_MASK, mask);
        cfg_write(CFG_MODE, md);
        cfg_write(CFG_GEN, N'(g));
    endtask

    task automatic wait_req(input bit which);
        int n = 0;
        while (!(which ? req1 : req0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL wait_req timeout on dut%0d", which);
        end
    endtask

    // Full handshake: ack, confirm in service, eoi, confirm back out.
    task automatic serve(input bit which);
        wait_req(which);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("in_service_after_ack", 32'(which ? ins1 : ins0), 32'd1);
        check("req_drop_after_ack", 32'(which ? req1 : req0), 32'd0);
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
        check("in_service_after_eoi", 32'(which ? ins1 : ins0), 32'd0);
    endtask

    task automatic reset0();
        rst0 = 1'b0;
        tick(2);
        rst0 = 1'b1;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; nmi = 1'b0; irq = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ack = 1'b0; eoi = 1'b0;
        tick(3);
        rst0 = 1'b1;
        tick(1);
        check("rst_irq_req", 32'(req0), 32'd0);
        check("rst_in_service", 32'(ins0), 32'd0);
        check("rst_pending", 32'(pend0), 32'd0);
        check("rst_irq_id", 32'({nmi0, id0}), 32'd0);

        // Fixed priority: pulse channels 2 and 5 together
        setup(8'hFF, 8'hFF, 1'b1);
        q0.push_back({1'b0, 3'd2});
        q0.push_back({1'b0, 3'd5});
        irq = 8'b0010_0100;
        tick(1);
        irq = '0;
        serve(0);
        serve(0);
        tick(2);
        check("fixed_pending_empty", 32'(pend0), 32'd0);

        // NMI and IRQ[0] rise together: NMI served first, then channel 0
        reset0();
        setup(8'hFF, 8'hFF, 1'b1);
        q0.push_back({1'b1, 3'd0});
        q0.push_back({1'b0, 3'd0});
        irq = 8'h01; nmi = 1'b1;
        tick(1);
        irq = '0; nmi = 1'b0;
        serve(0);
        serve(0);

        // Masked channel stays pending, no request; write-1-to-clear removes it
        reset0();
        setup(8'h00, 8'hFF, 1'b1);
        irq = 8'h08;
        tick(1);
        irq = '0;
        tick(4);
        check("masked_no_req", 32'(req0), 32'd0);
        check("masked_pending", 32'(pend0), 32'h08);
        cfg_write(CFG_CLR, 8'h08);
        check("w1c_pending", 32'(pend0), 32'd0);

        // Clear and set of bit 4 on one edge: set wins
        reset0();
        setup(8'hFF, 8'hFF, 1'b0);
        cfg_we = 1'b1; cfg_addr = CFG_CLR; cfg_wdata = 8'h10; irq = 8'h10;
        tick(1);
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; irq = '0;
        check("set_wins_pending", 32'(pend0), 32'h10);
        q0.push_back({1'b0, 3'd4});
        cfg_write(CFG_GEN, 8'h01);
        wait_req(0);
        ack = 1'b1; eoi = 1'b1;
        tick(1);
        ack = 1'b0; eoi = 1'b0;
        check("ack_eoi_same_edge_svc", 32'(ins0), 32'd1);
        check("ack_eoi_same_edge_req", 32'(req0), 32'd0);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        check("eoi_to_idle", 32'(ins0), 32'd0);

        // Reset while in service abandons everything
        reset0();
        setup(8'hFF, 8'hFF, 1'b1);
        q0.push_back({1'b0, 3'd2});
        irq = 8'b0010_0100;
        tick(1);
        irq = '0;
        wait_req(0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("mid_svc_in_service", 32'(ins0), 32'd1);
        check("mid_svc_pending5", 32'(pend0), 32'h20);
        rst0 = 1'b0;
        tick(1);
        rst0 = 1'b1;
        check("rst_svc_req", 32'(req0), 32'd0);
        check("rst_svc_in_service", 32'(ins0), 32'd0);
        check("rst_svc_pending", 32'(pend0), 32'd0);
        check("rst_svc_state", 32'(dut0.state), 32'(IDLE));
        tick(4);
        check("rst_svc_stays_idle", 32'(req0), 32'd0);

        // Rotating priority on the second instance: levels 1 and 6 held
        rst0 = 1'b0;
        rst1 = 1'b1;
        tick(1);
        setup(8'hFF, 8'h00, 1'b1);
        q1.push_back({1'b0, 3'd1});
        q1.push_back({1'b0, 3'd6});
        q1.push_back({1'b0, 3'd1});
        q1.push_back({1'b0, 3'd6});
        irq = 8'b0100_0010;
        serve(1);
        serve(1);
        serve(1);
        wait_req(1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        irq = '0;
        tick(3);
        check("rot_level_pending_gone", 32'(pend1), 32'd0);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        tick(4);
        check("rot_idle_after", 32'(req1), 32'd0);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
